// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg -- shared definitions for the boot-time RAM loader.
//   RAM_BYTES       : size of the ram256x8 target, also the overflow limit
//   BYTES_PER_WORD  : bytes packed into one word write
//   SIZE_BYTE/WORD  : encodings of the RAM Size strobe
//   loader_state_e  : mem_loader FSM states
// ---------------------------------------------------------------------------
package ppu_pkg;

  localparam int   RAM_BYTES      = 256;
  localparam int   BYTES_PER_WORD = 4;
  localparam logic SIZE_BYTE      = 1'b0;
  localparam logic SIZE_WORD      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE_W,
    ST_FLUSH,
    ST_HOLD,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/mem_loader_if.sv
// ---------------------------------------------------------------------------
// mem_loader_if -- byte stream in, ram256x8 write strobes out.
//   in_valid/in_ready/in_byte/in_last : producer-to-loader byte stream
//   E/RW/Size/Addd/DI                 : loader-to-RAM write port
// Modports:
//   slave  : the loader's view (consumes the stream, drives the RAM port)
//   master : the environment's view (produces the stream, observes the RAM)
// ---------------------------------------------------------------------------
interface mem_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;

  logic        E;
  logic        RW;
  logic        Size;
  logic [7:0]  Addd;
  logic [31:0] DI;

  modport slave (
    input  in_valid, in_byte, in_last,
    output in_ready, E, RW, Size, Addd, DI
  );

  modport master (
    output in_valid, in_byte, in_last,
    input  in_ready, E, RW, Size, Addd, DI
  );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer -- 4-byte shift register with a fill count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : drop all held bytes (wins over push/pop)
//   push_i     : shift byte_i in at the low end
//   pop_i      : retire the oldest held byte
//   byte_i     : byte to push
//   word_o     : held bytes, big-endian once four are present
//   fill_o     : number of bytes held (0..4)
//   oldest_o   : earliest-arrived byte still held
// ---------------------------------------------------------------------------
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [2:0]  fill_o,
  output logic [7:0]  oldest_o
);

  logic [31:0] data_q;
  logic [2:0]  fill_q;

  // NOTE: the data bytes are reset along with the count so DI can never
  // expose bytes from a load that a reset abandoned.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      data_q <= '0;
      fill_q <= '0;
    end else if (push_i) begin
      data_q <= {data_q[23:0], byte_i};
      fill_q <= fill_q + 3'd1;
    end else if (pop_i) begin
      fill_q <= fill_q - 3'd1;
    end
  end

  // Newest byte sits in [7:0], so the oldest is (fill-1) bytes up.
  // NOTE: the default arm gives oldest_o a value on every path, so no
  // latch is inferred.
  always_comb begin
    case (fill_q)
      3'd2:    oldest_o = data_q[15:8];
      3'd3:    oldest_o = data_q[23:16];
      3'd4:    oldest_o = data_q[31:24];
      default: oldest_o = data_q[7:0];
    endcase
  end

  assign word_o = data_q;
  assign fill_o = fill_q;

endmodule

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader -- streams bytes into a ram256x8 while holding the CPU in reset.
// Bytes are packed big-endian into word writes; a short tail is flushed as
// byte writes. cpu_R is released HOLD_CYCLES cycles after the final write.
// More than RAM_BYTES bytes without in_last ends the load with err=1 and the
// CPU kept in reset.
//
// Parameters:
//   BASE_ADDR   : RAM byte address of the first loaded byte
//   HOLD_CYCLES : cycles cpu_R stays high after the final write (>= 1)
// Ports:
//   clk, R_n   : clock, asynchronous active-low reset
//   start      : one-cycle pulse beginning a load (ignored while busy)
//   bus        : mem_loader_if.slave (byte stream in, RAM write port out)
//   cpu_R      : active-high CPU pipeline reset
//   busy/done/err, byte_count, checksum : status
// Build option:
//   MEM_LOADER_CHECKSUM_EN : when defined, checksum is the mod-256 sum of the
//   accepted bytes; otherwise checksum is tied to zero.
// ---------------------------------------------------------------------------
module mem_loader
  import ppu_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'd0,
  parameter int         HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             R_n,
  input  logic             start,
  mem_loader_if.slave      bus,
  output logic             cpu_R,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [8:0]       byte_count,
  output logic [7:0]       checksum
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  loader_state_e     state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [8:0]        count_q, count_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic        load_start;
  logic        accept;
  logic        pk_clear, pk_push, pk_pop;
  logic [31:0] pk_word;
  logic [2:0]  pk_fill;
  logic [7:0]  pk_oldest;

  byte_packer u_packer (
    .clk      (clk),
    .rst_n    (R_n),
    .clear_i  (pk_clear),
    .push_i   (pk_push),
    .pop_i    (pk_pop),
    .byte_i   (bus.in_byte),
    .word_o   (pk_word),
    .fill_o   (pk_fill),
    .oldest_o (pk_oldest)
  );

  assign accept = (state_q == ST_COLLECT) && bus.in_valid;

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      last_q  <= last_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    last_d       = last_q;
    err_d        = err_q;
    hold_d       = hold_q;
    load_start   = 1'b0;
    pk_clear     = 1'b0;
    pk_push      = 1'b0;
    pk_pop       = 1'b0;
    bus.in_ready = 1'b0;
    bus.E        = 1'b0;
    bus.RW       = 1'b0;
    bus.Size     = SIZE_BYTE;
    bus.Addd     = '0;
    bus.DI       = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_start = 1'b1;
          state_d    = ST_COLLECT;
          addr_d     = BASE_ADDR;
          count_d    = '0;
          last_d     = 1'b0;
          err_d      = 1'b0;
        end
      end

      ST_COLLECT: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          pk_push = 1'b1;
          if (count_q != 9'(RAM_BYTES)) count_d = count_q + 9'd1;
          // The word-complete check comes first: in_last on a 4th byte
          // still produces a word write, then goes straight to HOLD.
          if (pk_fill == 3'(BYTES_PER_WORD - 1)) begin
            state_d = ST_WRITE_W;
            last_d  = bus.in_last;
          end else if (bus.in_last) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_WRITE_W: begin
        bus.E    = 1'b1;
        bus.RW   = 1'b1;
        bus.Size = SIZE_WORD;
        bus.Addd = addr_q;
        bus.DI   = pk_word;
        addr_d   = addr_q + 8'(BYTES_PER_WORD);
        pk_clear = 1'b1;
        hold_d   = '0;
        if (last_q) begin
          state_d = ST_HOLD;
        end else if (count_q == 9'(RAM_BYTES)) begin
          // RAM is full and the stream has not ended: stop with the CPU
          // still in reset.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_FLUSH: begin
        bus.E    = 1'b1;
        bus.RW   = 1'b1;
        bus.Size = SIZE_BYTE;
        bus.Addd = addr_q;
        bus.DI   = {24'h0, pk_oldest};
        addr_d   = addr_q + 8'd1;
        pk_pop   = 1'b1;
        hold_d   = '0;
        if (pk_fill == 3'd1) state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = ST_DONE;
        else                                    hold_d  = hold_q + 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    pk_clear = pk_clear | load_start;
  end

  assign cpu_R      = !((state_q == ST_DONE) && !err_q);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign byte_count = count_q;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n)            sum_q <= '0;
    else if (load_start) sum_q <= '0;
    else if (accept)     sum_q <= sum_q + bus.in_byte;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader -- self-checking bench for mem_loader.
// A monitor records every RAM write and handshake; each load's record is
// compared with the write list derived from the byte list by plain
// word/tail arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_loader;

  localparam logic [7:0] BASE = 8'd0;
  localparam int         HOLD = 2;

  logic       clk = 1'b0;
  logic       R_n;
  logic       start;
  logic       cpu_R, busy, done, err;
  logic [8:0] byte_count;
  logic [7:0] checksum;

  mem_loader_if bus ();

  mem_loader #(.BASE_ADDR(BASE), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .R_n        (R_n),
    .start      (start),
    .bus        (bus.slave),
    .cpu_R      (cpu_R),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        size;
  } wr_t;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   acc_cnt = 0;
  int   strobe_viol = 0;
  int   fall_gap = -1;
  int   since_wr = 0;
  logic prev_cpu = 1'b1;

  // Mid-cycle monitor: values seen here are the ones the next edge uses.
  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) acc_cnt++;
    if (bus.E) begin
      got_q.push_back('{addr: bus.Addd, data: bus.DI, size: bus.Size});
      since_wr = 0;
      if (bus.in_ready || !bus.RW) strobe_viol++;
    end else begin
      since_wr++;
      if (bus.RW) strobe_viol++;
    end
    if (prev_cpu && !cpu_R) fall_gap = since_wr;
    prev_cpu = cpu_R;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int max_gap);
    bit ok = 1'b0;
    int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    tick();
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Expected writes: every complete group of four bytes is one big-endian
  // word at base+4w; leftover bytes follow as byte writes at the next
  // addresses. Addresses wrap at 256.
  task automatic model_writes(input logic [7:0] b[$], input int n);
    logic [7:0] addr = BASE;
    int words = n / 4;
    exp_q.delete();
    for (int w = 0; w < words; w++) begin
      exp_q.push_back('{addr: addr,
                        data: {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]},
                        size: 1'b1});
      addr = addr + 8'd4;
    end
    for (int j = 4 * words; j < n; j++) begin
      exp_q.push_back('{addr: addr, data: {24'h0, b[j]}, size: 1'b0});
      addr = addr + 8'd1;
    end
  endtask

  function automatic logic [7:0] model_sum(input logic [7:0] b[$], input int n);
    logic [7:0] s = 8'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
    for (int i = 0; i < n; i++) s = s + b[i];
`else
    if (n < 0) s = b[0];
`endif
    return s;
  endfunction

  task automatic compare_writes(input string tag);
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({tag, ".nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      logic [31:0] mask = exp_q[i].size ? 32'hFFFF_FFFF : 32'h0000_00FF;
      check($sformatf("%s.addr%0d", tag, i), {24'h0, got_q[i].addr}, {24'h0, exp_q[i].addr});
      check($sformatf("%s.size%0d", tag, i), {31'h0, got_q[i].size}, {31'h0, exp_q[i].size});
      check($sformatf("%s.data%0d", tag, i), got_q[i].data & mask, exp_q[i].data);
    end
  endtask

  task automatic begin_load();
    got_q.delete();
    acc_cnt     = 0;
    strobe_viol = 0;
    fall_gap    = -1;
  endtask

  task automatic run_load(input string tag, input logic [7:0] b[$], input int max_gap);
    int n = b.size();
    begin_load();
    pulse_start();
    for (int i = 0; i < n; i++) send_byte(b[i], i == n - 1, max_gap);
    wait_done(60);
    model_writes(b, n);
    compare_writes(tag);
    check({tag, ".byte_count"}, {23'h0, byte_count}, n);
    check({tag, ".accepted"}, acc_cnt, n);
    check({tag, ".checksum"}, {24'h0, checksum}, {24'h0, model_sum(b, n)});
    check({tag, ".done"}, {31'h0, done}, 32'd1);
    check({tag, ".err"}, {31'h0, err}, 32'd0);
    check({tag, ".busy"}, {31'h0, busy}, 32'd0);
    check({tag, ".cpu_R"}, {31'h0, cpu_R}, 32'd0);
    check({tag, ".strobes"}, strobe_viol, 32'd0);
    check({tag, ".hold_gap"}, fall_gap, HOLD + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"}, {31'h0, bus.in_ready}, 32'd0);
    check({tag, ".E"}, {31'h0, bus.E}, 32'd0);
    check({tag, ".RW"}, {31'h0, bus.RW}, 32'd0);
    check({tag, ".Size"}, {31'h0, bus.Size}, 32'd0);
    check({tag, ".Addd"}, {24'h0, bus.Addd}, 32'd0);
    check({tag, ".DI"}, bus.DI, 32'd0);
    check({tag, ".cpu_R"}, {31'h0, cpu_R}, 32'd1);
    check({tag, ".busy"}, {31'h0, busy}, 32'd0);
    check({tag, ".done"}, {31'h0, done}, 32'd0);
    check({tag, ".err"}, {31'h0, err}, 32'd0);
    check({tag, ".byte_count"}, {23'h0, byte_count}, 32'd0);
    check({tag, ".checksum"}, {24'h0, checksum}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq8[$];
    logic [7:0] seq6[$];
    logic [7:0] rnd[$];
    logic [7:0] big[$];

    R_n          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_last  = 1'b0;
    #2 R_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) tick();
    @(negedge clk);
    R_n = 1'b1;
    tick();

    // Eight bytes 00..07, contiguous then with random gaps.
    for (int i = 0; i < 8; i++) seq8.push_back(8'(i));
    run_load("seq8", seq8, 0);
    run_load("seq8_gaps", seq8, 3);

    // One word then a two-byte tail.
    seq6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_load("tail2", seq6, 0);

    // Checksum pattern.
    run_load("sum", '{8'h01, 8'h02, 8'h03, 8'h04}, 0);

    // Random lengths (covering tails of 0..3) and random gaps.
    for (int t = 0; t < 6; t++) begin
      int len = (t < 3) ? t + 1 : int'($urandom_range(5, 40));
      rnd.delete();
      for (int i = 0; i < len; i++) rnd.push_back(8'($urandom));
      run_load($sformatf("rand%0d", t), rnd, int'($urandom_range(0, 2)));
    end

    // 257 bytes offered without in_last: only 256 land, load ends in error.
    for (int i = 0; i < 257; i++) big.push_back(8'($urandom));
    begin_load();
    pulse_start();
    for (int i = 0; i < 256; i++) send_byte(big[i], 1'b0, 0);
    bus.in_valid = 1'b1;
    bus.in_byte  = big[256];
    wait_done(60);
    repeat (8) tick();
    model_writes(big, 256);
    compare_writes("ovf");
    check("ovf.err", {31'h0, err}, 32'd1);
    check("ovf.cpu_R", {31'h0, cpu_R}, 32'd1);
    check("ovf.done", {31'h0, done}, 32'd1);
    check("ovf.in_ready", {31'h0, bus.in_ready}, 32'd0);
    check("ovf.accepted", acc_cnt, 32'd256);
    check("ovf.byte_count", {23'h0, byte_count}, 32'd256);
    check("ovf.checksum", {24'h0, checksum}, {24'h0, model_sum(big, 256)});
    check("ovf.no_fall", fall_gap, -1);
    bus.in_valid = 1'b0;

    // Reset clears the error, then a reset in the middle of a load.
    R_n = 1'b0;
    #2 check_reset_outputs("reset_err");
    tick();
    R_n = 1'b1;
    tick();
    begin_load();
    pulse_start();
    send_byte(8'h5A, 1'b0, 0);
    send_byte(8'hA5, 1'b0, 0);
    check("midload.busy", {31'h0, busy}, 32'd1);
    R_n = 1'b0;
    #2 check_reset_outputs("reset_mid");
    check("midload.nwrites", got_q.size(), 32'd0);
    tick();
    R_n = 1'b1;
    tick();
    run_load("after_reset", '{8'h11, 8'h22, 8'h33, 8'h44}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
